// File: rtl/dsp_port_bridge.sv
// PicoBlaze port-mapped bridge to a text display cell bus, with a 4-entry cell FIFO.
// Define DSP_PORT_BRIDGE_FILL_EN to compile in the clear-screen fill engine.
module dsp_port_bridge #(
    parameter logic [7:0]  BASE = 8'h10,
    parameter int unsigned ROWS = 30,
    parameter int unsigned COLS = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  port_id,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic [7:0]  out_port,
    output logic [7:0]  in_port,
    output logic [4:0]  dsp_row,
    output logic [6:0]  dsp_col,
    output logic        dsp_en,
    output logic        dsp_wr,
    output logic [15:0] dsp_wr_data
);
    localparam logic [7:0] A_ROW    = BASE;
    localparam logic [7:0] A_COL    = BASE + 8'd1;
    localparam logic [7:0] A_ATR    = BASE + 8'd2;
    localparam logic [7:0] A_CHR    = BASE + 8'd3;
    localparam logic [7:0] A_STS    = BASE + 8'd4;
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

`ifdef DSP_PORT_BRIDGE_FILL_EN
    typedef enum logic [1:0] {IDLE, ISSUE, FILL} state_t;
`else
    typedef enum logic [0:0] {IDLE, ISSUE} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [7:0]  attr_q, attr_d;
    logic        ovf_q, ovf_d;
    logic [27:0] mem_q [4];
    logic [1:0]  wp_q, rp_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  in_port_q, in_port_d;
    logic        dsp_en_q;
    logic [4:0]  dsp_row_q;
    logic [6:0]  dsp_col_q;
    logic [15:0] dsp_data_q;

    logic        pres, pop, push_req, push_ok, full, empty, fill_busy;
    logic [4:0]  pres_row;
    logic [6:0]  pres_col;
    logic [15:0] pres_data;
    logic [7:0]  status;

`ifdef DSP_PORT_BRIDGE_FILL_EN
    logic        fpend_q, fpend_d;
    logic [4:0]  frow_q, frow_d;
    logic [6:0]  fcol_q, fcol_d;
    logic [7:0]  fattr_q, fattr_d;

    assign fill_busy = fpend_q || (state_q == FILL);
`else
    assign fill_busy = 1'b0;
`endif

    assign full     = (cnt_q == 3'd4);
    assign empty    = (cnt_q == 3'd0);
    assign push_req = write_strobe && (port_id == A_CHR);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign status   = {4'b0, ovf_q, fill_busy, empty, full};

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        pres      = 1'b0;
        pres_row  = mem_q[rp_q][27:23];
        pres_col  = mem_q[rp_q][22:16];
        pres_data = mem_q[rp_q][15:0];
`ifdef DSP_PORT_BRIDGE_FILL_EN
        fpend_d   = fpend_q;
        frow_d    = frow_q;
        fcol_d    = fcol_q;
        fattr_d   = fattr_q;
        if (write_strobe && port_id == A_STS && out_port[0] && !fill_busy)
            fpend_d = 1'b1;
`endif
        case (state_q)
            IDLE, ISSUE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    pres    = 1'b1;
                    state_d = ISSUE;
                end
`ifdef DSP_PORT_BRIDGE_FILL_EN
                else if (fpend_q) begin
                    // Attribute is frozen here so later attribute writes only affect new chars.
                    state_d = FILL;
                    fpend_d = 1'b0;
                    frow_d  = 5'd0;
                    fcol_d  = 7'd0;
                    fattr_d = attr_q;
                end
`endif
                else begin
                    state_d = IDLE;
                end
            end
`ifdef DSP_PORT_BRIDGE_FILL_EN
            FILL: begin
                pres      = 1'b1;
                pres_row  = frow_q;
                pres_col  = fcol_q;
                pres_data = {fattr_q, 8'h20};
                if (fcol_q == LAST_COL) begin
                    fcol_d = 7'd0;
                    if (frow_q == LAST_ROW) begin
                        frow_d  = 5'd0;
                        state_d = IDLE;
                    end else begin
                        frow_d = frow_q + 5'd1;
                    end
                end else begin
                    fcol_d = fcol_q + 7'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        attr_d = attr_q;
        if (write_strobe && port_id == A_ROW)
            row_d = (32'(out_port[4:0]) >= ROWS) ? 5'd0 : out_port[4:0];
        if (write_strobe && port_id == A_COL)
            col_d = (32'(out_port[6:0]) >= COLS) ? 7'd0 : out_port[6:0];
        if (write_strobe && port_id == A_ATR)
            attr_d = out_port;
        if (push_ok) begin
            if (col_q == LAST_COL) begin
                col_d = 7'd0;
                row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 7'd1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
        // Set wins over a simultaneous status-read clear.
        if (push_req && !push_ok)
            ovf_d = 1'b1;
        else if (read_strobe && port_id == A_STS)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
        case (port_id)
            A_ROW:   in_port_d = {3'b0, row_q};
            A_COL:   in_port_d = {1'b0, col_q};
            A_ATR:   in_port_d = attr_q;
            A_STS:   in_port_d = status;
            default: in_port_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= 5'd0;
            col_q      <= 7'd0;
            attr_q     <= 8'h07;
            ovf_q      <= 1'b0;
            wp_q       <= 2'd0;
            rp_q       <= 2'd0;
            cnt_q      <= 3'd0;
            in_port_q  <= 8'h00;
            dsp_en_q   <= 1'b0;
            dsp_row_q  <= 5'd0;
            dsp_col_q  <= 7'd0;
            dsp_data_q <= 16'h0000;
`ifdef DSP_PORT_BRIDGE_FILL_EN
            fpend_q    <= 1'b0;
            frow_q     <= 5'd0;
            fcol_q     <= 7'd0;
            fattr_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            attr_q    <= attr_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            in_port_q <= in_port_d;
            dsp_en_q  <= pres;
            if (push_ok) wp_q <= wp_q + 2'd1;
            if (pop)     rp_q <= rp_q + 2'd1;
            if (pres) begin
                dsp_row_q  <= pres_row;
                dsp_col_q  <= pres_col;
                dsp_data_q <= pres_data;
            end
`ifdef DSP_PORT_BRIDGE_FILL_EN
            fpend_q <= fpend_d;
            frow_q  <= frow_d;
            fcol_q  <= fcol_d;
            fattr_q <= fattr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= {row_q, col_q, attr_q, out_port};
    end

    assign in_port     = in_port_q;
    assign dsp_en      = dsp_en_q;
    assign dsp_wr      = dsp_en_q;
    assign dsp_row     = dsp_row_q;
    assign dsp_col     = dsp_col_q;
    assign dsp_wr_data = dsp_data_q;
endmodule

// File: tb/tb_dsp_port_bridge.sv
// Scoreboard bench for dsp_port_bridge: directed stimulus queues expected cells, a monitor checks each pulse.
`timescale 1ns/1ps
module tb_dsp_port_bridge;
    localparam logic [7:0] BASE  = 8'h10;
    localparam logic [7:0] A_ROW = BASE;
    localparam logic [7:0] A_COL = BASE + 8'd1;
    localparam logic [7:0] A_ATR = BASE + 8'd2;
    localparam logic [7:0] A_CHR = BASE + 8'd3;
    localparam logic [7:0] A_STS = BASE + 8'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id, out_port, in_port;
    logic        write_strobe, read_strobe;
    logic [4:0]  dsp_row;
    logic [6:0]  dsp_col;
    logic        dsp_en, dsp_wr;
    logic [15:0] dsp_wr_data;

    always #5 clk = ~clk;

    dsp_port_bridge #(.BASE(BASE), .ROWS(30), .COLS(80)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
        .dsp_row(dsp_row), .dsp_col(dsp_col), .dsp_en(dsp_en), .dsp_wr(dsp_wr),
        .dsp_wr_data(dsp_wr_data)
    );

    typedef struct {
        logic [4:0]  r;
        logic [6:0]  c;
        logic [15:0] d;
        int          cy;
        bit          fill;
        bit          first;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0, cyc = 0, npulse = 0, fill_seen = 0, last_cyc = 0;
    exp_t e;
    bit   ok;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every displayed cell must match the head of the scoreboard.
    always @(negedge clk) begin
        if (dsp_wr !== dsp_en) begin
            total++; bad++;
            $display("FAIL dsp_wr_vs_en: got wr=%b required %b", dsp_wr, dsp_en);
        end
        if (dsp_en === 1'b1) begin
            npulse++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got row=%0d col=%0d data=%h required no pulse",
                         dsp_row, dsp_col, dsp_wr_data);
            end else begin
                e  = sb.pop_front();
                ok = (dsp_row === e.r) && (dsp_col === e.c) && (dsp_wr_data === e.d);
                if (e.cy >= 0 && cyc != e.cy) ok = 1'b0;
                if (e.fill && !e.first && cyc != last_cyc + 1) ok = 1'b0;
                if (e.fill) fill_seen++;
                if (!ok) begin
                    bad++;
                    $display("FAIL cell: got row=%0d col=%0d data=%h cyc=%0d required row=%0d col=%0d data=%h cyc=%0d",
                             dsp_row, dsp_col, dsp_wr_data, cyc, e.r, e.c, e.d, e.cy);
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    // Char write whose cell is expected; timed cells must show two cycles after the write cycle.
    task automatic wch(input logic [7:0] ch, input logic [4:0] r, input logic [6:0] c,
                       input logic [7:0] at, input bit timed);
        wr(A_CHR, ch);
        sb.push_back('{r, c, {at, ch}, timed ? cyc + 1 : -1, 1'b0, 1'b0});
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        port_id = a; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        chk(nm, in_port, exp);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin tick(); n++; end
        chk("drain_left", sb.size(), 0);
        tick(2);
    endtask

    task automatic push_fill(input logic [7:0] at);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                sb.push_back('{5'(r), 7'(c), {at, 8'h20}, -1, 1'b1, (r == 0 && c == 0)});
    endtask

    initial begin
        reset = 1'b1; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0;
        tick(3);
        chk("rst_dsp_en", dsp_en, 0);
        chk("rst_dsp_row", dsp_row, 0);
        chk("rst_dsp_col", dsp_col, 0);
        chk("rst_dsp_data", dsp_wr_data, 0);
        chk("rst_in_port", in_port, 0);
        reset = 1'b0;
        tick();
        rd(A_ROW, 8'h00, "rst_row");
        rd(A_COL, 8'h00, "rst_col");
        rd(A_ATR, 8'h07, "rst_attr");
        rd(A_STS, 8'h02, "rst_status");

        // Single cell
        wr(A_ROW, 8'd2); wr(A_COL, 8'd5); wr(A_ATR, 8'h1E);
        wch(8'h41, 5'd2, 7'd5, 8'h1E, 1'b1);
        tick(3);
        rd(A_STS, 8'h02, "sts_after_cell");
        rd(A_ROW, 8'd2, "row_after_cell");
        rd(A_COL, 8'd6, "col_after_cell");

        // Out-of-range cursor values store 0
        wr(A_ROW, 8'd30); rd(A_ROW, 8'd0, "row_clamp");
        wr(A_COL, 8'd80); rd(A_COL, 8'd0, "col_clamp");

        // Screen-end wrap
        wr(A_ROW, 8'd29); wr(A_COL, 8'd79);
        rd(A_ROW, 8'd29, "row_29");
        rd(A_COL, 8'd79, "col_79");
        wch(8'h41, 5'd29, 7'd79, 8'h1E, 1'b1);
        wch(8'h42, 5'd0, 7'd0, 8'h1E, 1'b1);
        tick(3);
        rd(A_ROW, 8'd0, "row_after_wrap");
        rd(A_COL, 8'd1, "col_after_wrap");

        // Line-end wrap
        wr(A_ROW, 8'd3); wr(A_COL, 8'd79); wr(A_ATR, 8'h55);
        wch(8'h43, 5'd3, 7'd79, 8'h55, 1'b1);
        rd(A_ROW, 8'd4, "row_line_wrap");
        rd(A_COL, 8'd0, "col_line_wrap");

        // Back-to-back chars stream through without loss
        wr(A_ROW, 8'd0); wr(A_COL, 8'd0); wr(A_ATR, 8'h07);
        for (int i = 0; i < 5; i++) wch(8'(8'h30 + i), 5'd0, 7'(i), 8'h07, 1'b1);
        tick(3);
        rd(A_STS, 8'h02, "sts_after_burst");
        drain(50);

        // Unmapped / write-only addresses read 0
        rd(A_CHR, 8'h00, "rd_char_addr");
        rd(BASE + 8'd5, 8'h00, "rd_unmapped_5");
        rd(8'h00, 8'h00, "rd_unmapped_0");

`ifdef DSP_PORT_BRIDGE_FILL_EN
        // Full-screen fill, chars pushed during fill overflow the FIFO
        wr(A_ROW, 8'd0); wr(A_COL, 8'd0); wr(A_ATR, 8'h07);
        fill_seen = 0;
        wr(A_STS, 8'h01);
        push_fill(8'h07);
        rd(A_STS, 8'h06, "sts_fill_pending");
        wr(A_ATR, 8'h33);
        for (int i = 0; i < 4; i++) wch(8'(8'h61 + i), 5'd0, 7'(i), 8'h33, 1'b0);
        wr(A_CHR, 8'h65);
        rd(A_STS, 8'h0D, "sts_overflow");
        rd(A_STS, 8'h05, "sts_ovf_cleared");
        rd(A_COL, 8'd4, "col_after_drop");
        drain(3000);
        chk("fill_pulse_count", fill_seen, 2400);
        rd(A_STS, 8'h02, "sts_fill_done");

        // Reset in the middle of a fill
        wr(A_ATR, 8'h07);
        fill_seen = 0;
        wr(A_STS, 8'h01);
        push_fill(8'h07);
        begin
            int n = 0;
            while (fill_seen < 100 && n < 500) begin tick(); n++; end
        end
        chk("fill_reach_100", (fill_seen >= 100), 1);
        reset = 1'b1;
        tick();
        sb.delete();
        chk("rst_mid_fill_en", dsp_en, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("no_pulse_after_rst", dsp_en, 0);
        rd(A_STS, 8'h02, "sts_after_rst");
        rd(A_ROW, 8'd0, "row_after_rst");
        rd(A_COL, 8'd0, "col_after_rst");
        rd(A_ATR, 8'h07, "attr_after_rst");
`else
        // Without the fill engine the command register does nothing
        begin
            int n0;
            n0 = npulse;
            wr(A_STS, 8'h01);
            tick(20);
            chk("no_fill_pulses", npulse, n0);
        end
        rd(A_STS, 8'h02, "sts_no_fill");
`endif

        drain(100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
